// File: rtl/seq_detect_param.sv
// seq_detect_param
// Parametrised Moore serial-pattern detector with sample enable and a
// saturating match counter.
//
// The state index k (0..PATTERN_LEN) is the number of pattern bits matched.
// Next-state tables for in=0 and in=1 are built at elaboration by a
// constant function (KMP automaton), so the run-time logic is a mux.
//
// Parameters:
//   PATTERN_LEN  pattern length, 2..16
//   PATTERN      pattern bits, PATTERN[PATTERN_LEN-1] is received first
//   OVERLAP      1: overlapping matches allowed, 0: restart from S0 after MATCH
//   CNT_W        match counter width
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in           serial data bit
//   en           sample qualifier, in is consumed only when en=1
//   clr_cnt      synchronous clear of match_count (wins over increment)
//   out          registered match flag, high while in MATCH state
//   progress     current state index (bits of pattern matched)
//   match_count  saturating count of matches
module seq_detect_param #(
  parameter int                     PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b11011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in,
  input  logic                             en,
  input  logic                             clr_cnt,
  output logic                             out,
  output logic [$clog2(PATTERN_LEN+1)-1:0] progress,
  output logic [CNT_W-1:0]                 match_count
);

  localparam int SW    = $clog2(PATTERN_LEN + 1);
  localparam int TBL_W = (PATTERN_LEN + 1) * SW;
  localparam logic [SW-1:0]    MATCH_ST = SW'(PATTERN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Pattern bit j counted from the first bit received.
  function automatic logic pat_bit(input int j);
    logic [PATTERN_LEN-1:0] sh;
    sh = PATTERN >> (PATTERN_LEN - 1 - j);
    return sh[0];
  endfunction

  // Next state for every current state k given consumed bit b.
  // The consumed string is prefix(k) followed by b; the next state is the
  // longest suffix of that string which is also a pattern prefix. From
  // MATCH this naturally starts at the full-pattern border; without
  // overlap MATCH behaves like S0.
  function automatic logic [TBL_W-1:0] build_table(input logic b);
    logic [TBL_W-1:0] t;
    logic [SW-1:0]    nxt;
    logic             ok;
    logic             sb;
    int               kk;
    int               pos;
    t = '0;
    for (int k = 0; k <= PATTERN_LEN; k++) begin
      kk  = (k == PATTERN_LEN && !OVERLAP) ? 0 : k;
      nxt = '0;
      for (int l = 1; l <= PATTERN_LEN; l++) begin
        if (l <= kk + 1) begin
          ok = 1'b1;
          for (int j = 0; j < l; j++) begin
            pos = kk + 1 - l + j;
            sb  = (pos < kk) ? pat_bit(pos) : b;
            if (sb != pat_bit(j)) ok = 1'b0;
          end
          if (ok) nxt = SW'(l);
        end
      end
      t = t | (TBL_W'(nxt) << (k * SW));
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] NEXT0 = build_table(1'b0);
  localparam logic [TBL_W-1:0] NEXT1 = build_table(1'b1);

  logic [SW-1:0]    state_q, state_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TBL_W-1:0] row_sh;

  always_comb begin
    state_d = state_q;
    row_sh  = (in ? NEXT1 : NEXT0) >> (state_q * SW);
    if (en) state_d = row_sh[SW-1:0];
    out_d = (state_d == MATCH_ST);

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (en && (state_d == MATCH_ST) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out         = out_q;
  assign progress    = state_q;
  assign match_count = cnt_q;

endmodule
